// File: rtl/ir_prefetch_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ir_prefetch_decoder
//  Description : Instruction register / decoder with a small prefetch FIFO.
//                Instruction words are buffered in a DEPTH-entry FIFO. They
//                are assembled into one- or two-word instructions (opcode
//                word, then an optional operand word). One decoded
//                instruction at a time is presented to the controller over a
//                VALID/ACK handshake. A HALT instruction parks the decoder
//                in a sticky halted state that only RESUME leaves.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W  : instruction / operand word width (>= 8)
//    OPC_W   : opcode field width, taken from D[DATA_W-1 -: OPC_W]
//    DEPTH   : prefetch FIFO depth in words (power of two, >= 2)
//  Ports
//    CLK      in   clock, rising edge
//    RST      in   asynchronous active-high reset
//    D        in   instruction or operand word from memory
//    IIR      in   write strobe, pushes D into the FIFO
//    FULL     out  FIFO holds DEPTH words
//    OVF      out  sticky overflow: push attempted while full without a pop
//    VALID    out  a decoded instruction is presented
//    ACK      in   controller accepts the presented instruction
//    RESUME   in   leave the halted state
//    HALT..ILLEGAL out  one-hot decode
//    OPERAND  out  operand word of the last two-word instruction
//    SHAMT    out  low OPC_W bits of the last opcode word
// ============================================================================
module ir_prefetch_decoder #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] D,
    input  logic              IIR,
    output logic              FULL,
    output logic              OVF,
    output logic              VALID,
    input  logic              ACK,
    input  logic              RESUME,
    output logic              HALT,
    output logic              LD,
    output logic              ADD,
    output logic              SUB,
    output logic              AND,
    output logic              OR,
    output logic              XOR,
    output logic              SHL,
    output logic              ILLEGAL,
    output logic [DATA_W-1:0] OPERAND,
    output logic [OPC_W-1:0]  SHAMT
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_aw = $clog2(DEPTH);

    localparam logic [c_aw-1:0] c_ptr_one  = (c_aw)'(1);
    localparam logic [c_aw:0]   c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw:0]   c_cnt_zero = '0;
    localparam logic [c_aw:0]   c_cnt_full = (c_aw+1)'(DEPTH);

    localparam logic [OPC_W-1:0] c_op_nop  = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_op_ld   = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_op_add  = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_op_sub  = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_op_and  = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_op_or   = OPC_W'(5);
    localparam logic [OPC_W-1:0] c_op_xor  = OPC_W'(6);
    localparam logic [OPC_W-1:0] c_op_shl  = OPC_W'(7);
    localparam logic [OPC_W-1:0] c_op_halt = {OPC_W{1'b1}};

    // Bit positions inside the one-hot decode vector
    localparam int c_b_halt    = 8;
    localparam int c_b_ld      = 7;
    localparam int c_b_add     = 6;
    localparam int c_b_sub     = 5;
    localparam int c_b_and     = 4;
    localparam int c_b_or      = 3;
    localparam int c_b_xor     = 2;
    localparam int c_b_shl     = 1;
    localparam int c_b_illegal = 0;

    localparam logic [8:0] c_dec_none = '0;
    localparam logic [8:0] c_dec_halt = 9'b1_0000_0000;

    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_ARG   = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Opcode helpers
    // ------------------------------------------------------------------------
    // HALT is tested first so that it wins even for narrow opcode fields
    // where all-ones could alias a regular code.
    function automatic logic [8:0] decode_onehot(input logic [OPC_W-1:0] opc);
        logic [8:0] v;
        v = '0;
        if (opc == c_op_halt)     v[c_b_halt]    = 1'b1;
        else if (opc == c_op_ld)  v[c_b_ld]      = 1'b1;
        else if (opc == c_op_add) v[c_b_add]     = 1'b1;
        else if (opc == c_op_sub) v[c_b_sub]     = 1'b1;
        else if (opc == c_op_and) v[c_b_and]     = 1'b1;
        else if (opc == c_op_or)  v[c_b_or]      = 1'b1;
        else if (opc == c_op_xor) v[c_b_xor]     = 1'b1;
        else if (opc == c_op_shl) v[c_b_shl]     = 1'b1;
        else if (opc != c_op_nop) v[c_b_illegal] = 1'b1;
        return v;
    endfunction

    function automatic logic is_two_word(input logic [OPC_W-1:0] opc);
        return (opc != c_op_halt) && (opc >= c_op_ld) && (opc <= c_op_xor);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              r_ovf;

    state_t            r_state;
    logic              r_valid;
    logic [8:0]        r_dec;
    logic [OPC_W-1:0]  r_pend_opc;
    logic [DATA_W-1:0] r_operand;
    logic [OPC_W-1:0]  r_shamt;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [DATA_W-1:0] w_head;
    logic [OPC_W-1:0]  w_head_opc;

    assign w_empty    = (r_count == c_cnt_zero);
    assign w_full     = (r_count == c_cnt_full);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_opc = w_head[DATA_W-1 -: OPC_W];

    // Only the two fetch states consume words; issue and halt never pop.
    assign w_pop  = ((r_state == S_OP) || (r_state == S_ARG)) && !w_empty;
    // A pop on the same edge frees a slot, so a push while full is accepted.
    assign w_push = IIR && (!w_full || w_pop);

    // ------------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------------
    // Storage is not reset: the pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= D;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
            if (IIR && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Assembly / issue FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_OP;
            r_valid    <= 1'b0;
            r_dec      <= '0;
            r_pend_opc <= '0;
            r_operand  <= '0;
            r_shamt    <= '0;
        end else begin
            case (r_state)
                S_OP: begin
                    if (!w_empty) begin
                        r_shamt    <= w_head[OPC_W-1:0];
                        r_pend_opc <= w_head_opc;
                        if (w_head_opc == c_op_nop) begin
                            // NOP is swallowed here and never issued.
                            r_state <= S_OP;
                        end else if (is_two_word(w_head_opc)) begin
                            r_state <= S_ARG;
                        end else begin
                            r_valid <= 1'b1;
                            r_dec   <= decode_onehot(w_head_opc);
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_ARG: begin
                    if (!w_empty) begin
                        r_operand <= w_head;
                        r_valid   <= 1'b1;
                        r_dec     <= decode_onehot(r_pend_opc);
                        r_state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (ACK) begin
                        r_valid <= 1'b0;
                        if (r_dec[c_b_halt]) begin
                            // HALT stays asserted while parked.
                            r_dec   <= c_dec_halt;
                            r_state <= S_HALT;
                        end else begin
                            r_dec   <= c_dec_none;
                            r_state <= S_OP;
                        end
                    end
                end

                S_HALT: begin
                    if (RESUME) begin
                        r_dec   <= c_dec_none;
                        r_state <= S_OP;
                    end
                end

                default: begin
                    r_state <= S_OP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign FULL    = w_full;
    assign OVF     = r_ovf;
    assign VALID   = r_valid;
    assign HALT    = r_dec[c_b_halt];
    assign LD      = r_dec[c_b_ld];
    assign ADD     = r_dec[c_b_add];
    assign SUB     = r_dec[c_b_sub];
    assign AND     = r_dec[c_b_and];
    assign OR      = r_dec[c_b_or];
    assign XOR     = r_dec[c_b_xor];
    assign SHL     = r_dec[c_b_shl];
    assign ILLEGAL = r_dec[c_b_illegal];
    assign OPERAND = r_operand;
    assign SHAMT   = r_shamt;

endmodule
`default_nettype wire

// File: tb/tb_ir_prefetch_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ir_prefetch_decoder
//  Description : Self-checking bench for ir_prefetch_decoder. Directed
//                scenarios check latency, handshake, halt, FIFO full and
//                overflow and reset; a randomized run compares the issued
//                instruction stream against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_prefetch_decoder;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;
    localparam int DEPTH  = 4;

    // Expected one-hot patterns, ordered {HALT,LD,ADD,SUB,AND,OR,XOR,SHL,ILLEGAL}
    localparam logic [8:0] E_NONE = 9'h000;
    localparam logic [8:0] E_HALT = 9'h100;
    localparam logic [8:0] E_LD   = 9'h080;
    localparam logic [8:0] E_ADD  = 9'h040;
    localparam logic [8:0] E_SUB  = 9'h020;
    localparam logic [8:0] E_AND  = 9'h010;
    localparam logic [8:0] E_OR   = 9'h008;
    localparam logic [8:0] E_XOR  = 9'h004;
    localparam logic [8:0] E_SHL  = 9'h002;
    localparam logic [8:0] E_ILL  = 9'h001;

    typedef struct {
        logic [8:0] dec;
        logic [7:0] operand;
        logic [3:0] shamt;
        bit         two;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic [DATA_W-1:0] D;
    logic              IIR;
    logic              FULL;
    logic              OVF;
    logic              VALID;
    logic              ACK;
    logic              RESUME;
    logic              HALT, LD, ADD, SUB, AND, OR, XOR, SHL, ILLEGAL;
    logic [DATA_W-1:0] OPERAND;
    logic [OPC_W-1:0]  SHAMT;
    logic [8:0]        dec_obs;

    int checks = 0;
    int errors = 0;

    assign dec_obs = {HALT, LD, ADD, SUB, AND, OR, XOR, SHL, ILLEGAL};

    ir_prefetch_decoder #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .D(D), .IIR(IIR), .FULL(FULL), .OVF(OVF),
        .VALID(VALID), .ACK(ACK), .RESUME(RESUME),
        .HALT(HALT), .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .XOR(XOR), .SHL(SHL), .ILLEGAL(ILLEGAL),
        .OPERAND(OPERAND), .SHAMT(SHAMT)
    );

    always #5 CLK = ~CLK;

    // Reference decode, straight from the opcode table
    function automatic logic [8:0] model_dec(input logic [3:0] opc);
        case (opc)
            4'd0:    return E_NONE;
            4'd1:    return E_LD;
            4'd2:    return E_ADD;
            4'd3:    return E_SUB;
            4'd4:    return E_AND;
            4'd5:    return E_OR;
            4'd6:    return E_XOR;
            4'd7:    return E_SHL;
            4'd15:   return E_HALT;
            default: return E_ILL;
        endcase
    endfunction

    // Stimulus helpers: start and end just after a falling edge.
    task automatic push(input logic [7:0] w);
        D = w; IIR = 1'b1;
        @(negedge CLK);
        IIR = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset();
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", VALID); end
        checks++; if (dec_obs !== E_NONE) begin errors++; $display("FAIL reset_dec: got %h expected %h", dec_obs, E_NONE); end
        checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", FULL); end
        checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
        checks++; if (OPERAND !== 8'h00) begin errors++; $display("FAIL reset_operand: got %h expected 00", OPERAND); end
        checks++; if (SHAMT !== 4'h0) begin errors++; $display("FAIL reset_shamt: got %h expected 0", SHAMT); end
    endtask

    task automatic test_shl();
        push(8'h72);
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL shl_early: got %b expected 0", VALID); end
        step(1);
        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL shl_valid: got %b expected 1", VALID); end
        checks++; if (dec_obs !== E_SHL) begin errors++; $display("FAIL shl_dec: got %h expected %h", dec_obs, E_SHL); end
        checks++; if (SHAMT !== 4'h2) begin errors++; $display("FAIL shl_shamt: got %h expected 2", SHAMT); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL shl_ack_valid: got %b expected 0", VALID); end
        checks++; if (dec_obs !== E_NONE) begin errors++; $display("FAIL shl_ack_dec: got %h expected %h", dec_obs, E_NONE); end
    endtask

    task automatic test_two_word();
        ACK = 1'b1;
        push(8'h20);
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL add_early0: got %b expected 0", VALID); end
        push(8'h5A);
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL add_early1: got %b expected 0", VALID); end
        step(1);
        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", VALID); end
        checks++; if (dec_obs !== E_ADD) begin errors++; $display("FAIL add_dec: got %h expected %h", dec_obs, E_ADD); end
        checks++; if (OPERAND !== 8'h5A) begin errors++; $display("FAIL add_operand: got %h expected 5a", OPERAND); end
        step(1);
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL add_ack: got %b expected 0", VALID); end
        ACK = 1'b0;
        // opcode alone: must wait for the operand
        push(8'h20);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL add_wait_arg: got %b expected 0", VALID); end
        end
        push(8'h5A);
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL add_arg_early: got %b expected 0", VALID); end
        step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_ADD) begin errors++; $display("FAIL add2_issue: got valid=%b dec=%h expected valid=1 dec=%h", VALID, dec_obs, E_ADD); end
        checks++; if (OPERAND !== 8'h5A) begin errors++; $display("FAIL add2_operand: got %h expected 5a", OPERAND); end
        ACK = 1'b1; step(1); ACK = 1'b0;
    endtask

    task automatic test_halt();
        push(8'hF0);
        step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_HALT) begin errors++; $display("FAIL halt_issue: got valid=%b dec=%h expected valid=1 dec=%h", VALID, dec_obs, E_HALT); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        checks++; if (VALID !== 1'b0 || dec_obs !== E_HALT) begin errors++; $display("FAIL halt_parked: got valid=%b dec=%h expected valid=0 dec=%h", VALID, dec_obs, E_HALT); end
        push(8'h10); push(8'h33);
        ACK = 1'b1; step(2); ACK = 1'b0;
        checks++; if (VALID !== 1'b0 || dec_obs !== E_HALT) begin errors++; $display("FAIL halt_hold: got valid=%b dec=%h expected valid=0 dec=%h", VALID, dec_obs, E_HALT); end
        checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL halt_full2: got %b expected 0", FULL); end
        push(8'h00); push(8'h00);
        checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL halt_full4: got %b expected 1", FULL); end
        RESUME = 1'b1; step(1); RESUME = 1'b0;
        checks++; if (dec_obs !== E_NONE || VALID !== 1'b0) begin errors++; $display("FAIL resume_clear: got valid=%b dec=%h expected valid=0 dec=%h", VALID, dec_obs, E_NONE); end
        step(1);
        checks++; if (VALID !== 1'b0 || FULL !== 1'b0) begin errors++; $display("FAIL resume_fetch: got valid=%b full=%b expected 0 0", VALID, FULL); end
        step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_LD) begin errors++; $display("FAIL ld_issue: got valid=%b dec=%h expected valid=1 dec=%h", VALID, dec_obs, E_LD); end
        checks++; if (OPERAND !== 8'h33) begin errors++; $display("FAIL ld_operand: got %h expected 33", OPERAND); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL halt_nop_drain: got %b expected 0", VALID); end
        end
    endtask

    task automatic test_overflow();
        int n;
        push(8'h72); step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_SHL) begin errors++; $display("FAIL ovf_hold_issue: got valid=%b dec=%h expected valid=1 dec=%h", VALID, dec_obs, E_SHL); end
        push(8'h30); push(8'h44); push(8'h50);
        checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL ovf_full3: got %b expected 0", FULL); end
        push(8'h66);
        checks++; if (FULL !== 1'b1 || OVF !== 1'b0) begin errors++; $display("FAIL ovf_full4: got full=%b ovf=%b expected 1 0", FULL, OVF); end
        push(8'h99);
        checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", OVF); end
        push(8'hAA);
        checks++; if (FULL !== 1'b1 || OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got full=%b ovf=%b expected 1 1", FULL, OVF); end
        checks++; if (VALID !== 1'b1 || dec_obs !== E_SHL) begin errors++; $display("FAIL ovf_issue_stable: got valid=%b dec=%h expected valid=1 dec=%h", VALID, dec_obs, E_SHL); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        checks++; if (VALID !== 1'b0 || FULL !== 1'b1) begin errors++; $display("FAIL ovf_after_ack: got valid=%b full=%b expected 0 1", VALID, FULL); end
        push(8'hE5);   // coincides with the pop of 0x30
        checks++; if (FULL !== 1'b1 || OVF !== 1'b1) begin errors++; $display("FAIL ovf_push_pop_full: got full=%b ovf=%b expected 1 1", FULL, OVF); end
        step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_SUB || OPERAND !== 8'h44) begin errors++; $display("FAIL ovf_sub: got valid=%b dec=%h op=%h expected 1 %h 44", VALID, dec_obs, OPERAND, E_SUB); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        step(2);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_OR || OPERAND !== 8'h66) begin errors++; $display("FAIL ovf_or: got valid=%b dec=%h op=%h expected 1 %h 66", VALID, dec_obs, OPERAND, E_OR); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        n = 0;
        while (VALID !== 1'b1 && n < 10) begin step(1); n++; end
        checks++; if (VALID !== 1'b1 || dec_obs !== E_ILL || SHAMT !== 4'h5) begin errors++; $display("FAIL ovf_tail: got valid=%b dec=%h shamt=%h expected 1 %h 5", VALID, dec_obs, SHAMT, E_ILL); end
        ACK = 1'b1; step(1); ACK = 1'b0;
    endtask

    task automatic test_illegal_nop();
        push(8'h90); step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_ILL || SHAMT !== 4'h0) begin errors++; $display("FAIL illegal: got valid=%b dec=%h shamt=%h expected 1 %h 0", VALID, dec_obs, SHAMT, E_ILL); end
        ACK = 1'b1; step(1); ACK = 1'b0;
        push(8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (VALID !== 1'b0 || dec_obs !== E_NONE) begin errors++; $display("FAIL nop_issued: got valid=%b dec=%h expected 0 %h", VALID, dec_obs, E_NONE); end
        end
        push(8'h72); step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_SHL) begin errors++; $display("FAIL after_nop: got valid=%b dec=%h expected 1 %h", VALID, dec_obs, E_SHL); end
        ACK = 1'b1; step(1); ACK = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Reset while waiting in S_ARG after popping 0x30
        push(8'h30); step(1);
        #2 RST = 1'b1;
        #1;
        checks++; if (VALID !== 1'b0 || dec_obs !== E_NONE) begin errors++; $display("FAIL rst_arg_dec: got valid=%b dec=%h expected 0 %h", VALID, dec_obs, E_NONE); end
        checks++; if (OVF !== 1'b0 || FULL !== 1'b0 || OPERAND !== 8'h00 || SHAMT !== 4'h0) begin errors++; $display("FAIL rst_arg_state: got ovf=%b full=%b op=%h shamt=%h expected 0 0 00 0", OVF, FULL, OPERAND, SHAMT); end
        @(negedge CLK); RST = 1'b0;
        // Reset while an instruction is presented and the FIFO is full
        push(8'h72); step(1);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        checks++; if (FULL !== 1'b1 || VALID !== 1'b1) begin errors++; $display("FAIL rst_pre: got full=%b valid=%b expected 1 1", FULL, VALID); end
        #2 RST = 1'b1;
        #1;
        checks++; if (VALID !== 1'b0 || dec_obs !== E_NONE || FULL !== 1'b0) begin errors++; $display("FAIL rst_async: got valid=%b dec=%h full=%b expected 0 %h 0", VALID, dec_obs, FULL, E_NONE); end
        @(negedge CLK); RST = 1'b0;
        push(8'h40); push(8'h0F); step(1);
        checks++; if (VALID !== 1'b1 || dec_obs !== E_AND || OPERAND !== 8'h0F) begin errors++; $display("FAIL rst_and: got valid=%b dec=%h op=%h expected 1 %h 0f", VALID, dec_obs, OPERAND, E_AND); end
        ACK = 1'b1; step(1); ACK = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] words[$];
        exp_t       expq[$];
        exp_t       e;
        bit         halted;
        bit         prev_hold;
        int         gen;
        int         cyc;
        logic [3:0] opc;
        logic [3:0] lo;

        RST = 1'b1; @(negedge CLK); RST = 1'b0;
        halted = 1'b0; prev_hold = 1'b0; gen = 0; cyc = 0;
        while (cyc < 8000 && (gen < 400 || words.size() > 0 || expq.size() > 0)) begin
            // instruction generator feeding the word queue
            if (words.size() < 6 && gen < 400) begin
                opc = 4'($urandom_range(0, 15));
                lo  = 4'($urandom_range(0, 15));
                words.push_back({opc, lo});
                if (opc != 4'd0) begin
                    e.dec     = model_dec(opc);
                    e.shamt   = lo;
                    e.two     = (opc >= 4'd1 && opc <= 4'd6);
                    e.operand = 8'($urandom_range(0, 255));
                    if (e.two) words.push_back(e.operand);
                    expq.push_back(e);
                end
                gen++;
            end

            // observe
            if (halted) begin
                checks++; if (VALID !== 1'b0 || dec_obs !== E_HALT) begin errors++; $display("FAIL rnd_halted: got valid=%b dec=%h expected 0 %h", VALID, dec_obs, E_HALT); end
            end else if (VALID === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious: got dec=%h expected no instruction", dec_obs);
                end else begin
                    e = expq[0];
                    if (dec_obs !== e.dec || SHAMT !== e.shamt || (e.two && OPERAND !== e.operand)) begin
                        errors++;
                        $display("FAIL rnd_issue: got dec=%h shamt=%h op=%h expected dec=%h shamt=%h op=%h", dec_obs, SHAMT, OPERAND, e.dec, e.shamt, e.operand);
                    end
                end
            end else begin
                checks++; if (dec_obs !== E_NONE || prev_hold) begin errors++; $display("FAIL rnd_idle: got valid=%b dec=%h held=%b expected dec=%h held=0", VALID, dec_obs, prev_hold, E_NONE); end
            end
            checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL rnd_ovf: got %b expected 0", OVF); end

            // drive
            ACK    = ($urandom_range(0, 2) == 0);
            RESUME = ($urandom_range(0, 3) == 0);
            prev_hold = (VALID === 1'b1) && !ACK;
            if (halted) begin
                if (RESUME) halted = 1'b0;
            end else if (VALID === 1'b1 && ACK && expq.size() > 0) begin
                e = expq.pop_front();
                if (e.dec == E_HALT) halted = 1'b1;
            end
            if (words.size() > 0 && FULL === 1'b0 && $urandom_range(0, 3) != 0) begin
                D = words.pop_front(); IIR = 1'b1;
            end else begin
                D = 8'($urandom_range(0, 255)); IIR = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        IIR = 1'b0; ACK = 1'b0; RESUME = 1'b0;
        checks++; if (words.size() != 0 || expq.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d words %0d instrs left expected 0 0", words.size(), expq.size()); end
    endtask

    initial begin
        RST = 1'b1; IIR = 1'b0; ACK = 1'b0; RESUME = 1'b0; D = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        test_reset();
        test_shl();
        test_two_word();
        test_halt();
        test_overflow();
        test_illegal_nop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_prefetch_decoder.md
Name: ir_prefetch_decoder

Overview:
- Parametrised successor to the model computer's instruction register and decoder.
- Buffers instruction words in a small prefetch FIFO.
- Assembles two-word instructions (opcode word plus operand word) and presents one decoded instruction at a time to the controller over a valid/ready handshake.
- Holds a sticky HALT state until the controller asserts RESUME.

Parameters:
- DATA_W, 8: instruction/operand word width (minimum 8).
- OPC_W, 4: opcode field width, taken from D[DATA_W-1 -: OPC_W].
- DEPTH, 4: prefetch FIFO depth in words (power of 2, minimum 2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- D  in  DATA_W  instruction or operand word from memory.
- IIR  in  1  write strobe; pushes D into the FIFO.
- FULL  out  1  FIFO holds DEPTH words.
- OVF  out  1  sticky; set when IIR is asserted while FULL and no pop occurs that cycle.
- VALID  out  1  a decoded instruction is presented.
- ACK  in  1  controller accepts the presented instruction.
- RESUME  in  1  leaves the halted state.
- HALT, LD, ADD, SUB, AND, OR, XOR, SHL, ILLEGAL  out  1 each  one-hot decode.
- OPERAND  out  DATA_W  operand word (two-word instructions).
- SHAMT  out  OPC_W  shift count, equal to the opcode word's low OPC_W bits.

Behaviour:
- Reset: all outputs 0, FIFO empty, OVF cleared, FSM in S_OP.
- Opcode encoding:
  - 0 NOP, 1 LD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SHL, all-ones HALT; any other code is ILLEGAL.
  - LD, ADD, SUB, AND, OR, XOR are two-word instructions. NOP, SHL, HALT and ILLEGAL are one-word.
- FIFO:
  - Push when IIR && (!FULL || pop this cycle).
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - A push while full with no pop is dropped and sets OVF. OVF clears only on RST.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: S_OP, S_ARG, S_ISSUE, S_HALT.
  - S_OP: if the FIFO is non-empty, pop and latch the opcode word.
    - NOP: stay in S_OP; never issued, consumes 1 cycle.
    - Two-word opcode: go to S_ARG.
    - Otherwise: go to S_ISSUE.
  - S_ARG: if the FIFO is non-empty, pop, latch OPERAND, go to S_ISSUE. Wait while empty.
  - S_ISSUE: VALID=1 with exactly one decode output high.
    - Outputs stay stable until ACK is sampled high.
    - On ACK: HALT goes to S_HALT; anything else goes to S_OP.
    - No pops occur in S_ISSUE.
  - S_HALT: VALID=0, HALT output held at 1, no pops; FIFO pushes still accepted. RESUME goes to S_OP and clears HALT on the same edge.
- Decode outputs are 0 whenever VALID=0, except HALT in S_HALT.
- OPERAND and SHAMT hold their last latched value between instructions.
- Latency: a one-word instruction pushed at edge k into an empty FIFO, with the FSM in S_OP, is popped at edge k+1 and gives VALID=1 after edge k+1. A two-word instruction whose operand is already present gives VALID=1 after edge k+2.
- RST asserted mid-instruction:
  - Immediately clears VALID, the decode outputs and the FIFO.
  - Any partially assembled instruction is discarded.
- ACK outside S_ISSUE and RESUME outside S_HALT are ignored.

Test Plan:
- Reset, then push 0x72 (SHL) -> VALID and SHL high one cycle after the pop edge, SHAMT=2, other decodes 0. ACK gives VALID=0 next cycle.
- Push 0x20 then 0x5A with ACK held high -> ADD issued, OPERAND=0x5A. Pushing 0x20 alone -> FSM waits in S_ARG with VALID=0 until 0x5A arrives.
- Push 0xF0, ACK, then push 0x10/0x33 -> HALT stays 1 and no LD issues; FULL reflects the buffered words. RESUME -> LD issues with OPERAND=0x33.
- Hold ACK=0 in S_ISSUE and push 6 words with DEPTH=4 -> FULL=1 after 4 pushes, OVF=1, extra words dropped. With FULL=1, push and pop in the same cycle -> count stays 4, OVF unchanged.
- Push 0x90 (illegal) -> ILLEGAL issued as a one-word instruction. Push 0x00 (NOP) -> consumed, never VALID.
- Assert RST while in S_ARG after 0x30 was popped -> all outputs 0, FIFO empty. Push 0x40/0x0F -> AND issued, OPERAND=0x0F.
